ddr_stream_writer: RTL
======================

// Module: ddr_stream_writer
// PURPOSE
//  Downstream consumer of setup_ddr: once setup_done is high, accepts a 256-bit word stream
//  (valid/ready) and writes it linearly into DDR as fixed-length Avalon-MM write bursts.
//  Buffers words in an internal FIFO so the stream never stalls mid-burst.
//  Sits between the SFP receive datapath and the EMIF Avalon slave, in the avalon_clk domain.
// PARAMETERS
//  DATA_W     256         stream / Avalon data width, bits
//  ADDR_W     25          Avalon word address width
//  BURST_LEN  16          beats per burst, 1..64 (fits 7-bit burstcount)
//  FIFO_DEPTH 64          buffer depth in words, power of two, >= 2*BURST_LEN
//  ADDR_BASE  25'h0000000 first word address of the ring region
//  ADDR_LIMIT 25'h1FFFFF0 last legal burst start address; next start wraps to ADDR_BASE
// PORTS
//  clk             in   1       single clock (Avalon domain)
//  rst_n           in   1       asynchronous, active-low reset
//  setup_done      in   1       from setup_ddr; writes permitted only while high
//  in_data         in   DATA_W  stream word
//  in_valid        in   1       in_data valid
//  in_ready        out  1       word accepted when in_valid & in_ready
//  in_flush        in   1       1-cycle pulse: write out residual words as a short burst
//  amm_addr        out  ADDR_W  burst start word address, held for whole burst
//  amm_writedata   out  DATA_W  current beat data
//  amm_write       out  1       write request
//  amm_byteenable  out  DATA_W/8 all ones whenever amm_write=1
//  amm_burstcount  out  7       beats in current burst, held for whole burst
//  amm_ready       in   1       slave ready (active-high; beat accepted when amm_write & amm_ready)
//  busy            out  1       FSM not in IDLE or FIFO non-empty
//  wrap_pulse      out  1       1-cycle pulse when next start address wraps to ADDR_BASE
//  words_written   out  32      count of beats accepted by slave, saturates at 2^32-1
// BEHAVIOUR
//  Reset (async assert, sync release): in_ready=0, amm_write=0, amm_addr=ADDR_BASE, amm_burstcount=0,
//   amm_writedata=0, amm_byteenable=0, busy=0, wrap_pulse=0, words_written=0; FIFO emptied; FSM=IDLE.
//  in_ready = setup_done & ~fifo_full (combinational from registered state); no word ever dropped.
//  FSM IDLE: if setup_done & (fifo_count>=BURST_LEN) -> LOAD; elif setup_done & flush_pend & fifo_count>0 -> LOAD.
//  LOAD (1 cycle): latch amm_burstcount = min(BURST_LEN, fifo_count); present first FIFO word -> BURST.
//  BURST: amm_write=1; each cycle with amm_ready=1 pops one word, advances data, beats_left--.
//   amm_ready=0: addr/data/burstcount/write held stable. Last accepted beat -> NEXT.
//  NEXT (1 cycle): amm_write=0; start += burstcount; if new start > ADDR_LIMIT -> ADDR_BASE + wrap_pulse. -> IDLE.
//  Burst never starts unless all its beats are already in the FIFO (burst never starved).
//  in_flush sets flush_pend; cleared when a short burst issues or FIFO reaches empty; flush with empty FIFO = no-op.
//  setup_done falling mid-burst: current burst completes; no new burst; in_ready drops next cycle.
//  Simultaneous push and pop on a full FIFO: push allowed only if ~full at cycle start (no bypass).
//  Address arithmetic modulo 2^ADDR_W before limit compare; burstcount always 1..BURST_LEN when amm_write=1.
// STRUCTURE
//  Package ddr_pkg: DDR_DATA_W, DDR_ADDR_W, DDR_BE_W, burstcount width, FSM state enum
//   (IDLE, LOAD, BURST, NEXT).
//  Sub-module ddr_wr_fifo: sync FIFO (DATA_W x FIFO_DEPTH), first-word-fall-through,
//   count/full/empty outputs. Top holds FSM, address generator, counters.
// TESTING
//  1 BURST_LEN=16, setup_done=1, push 16 words 0..15, amm_ready=1 -> one burst addr=0, bc=16, data 0..15, words_written=16.
//  2 As 1 with amm_ready toggling 1/0 each cycle -> addr/data/bc stable during stalls, 16 beats total, order intact.
//  3 Push 5 words, pulse in_flush -> single burst bc=5 at addr=0; next 16-word burst starts at addr=5.
//  4 ADDR_LIMIT=32, push 48 words -> bursts at 0,16,32 then wrap_pulse; fourth burst (16 more words) at addr 0.
//  5 setup_done=0, in_valid=1 -> in_ready=0, no amm_write; raise setup_done -> normal acceptance.
//  6 rst_n low during beat 7 of a burst -> amm_write=0 immediately, counters 0, FIFO empty; after release addr=ADDR_BASE.

Source files
------------

// File: rtl/ddr_pkg.sv
// Shared types and constants for the DDR stream writer slice.
package ddr_pkg;

  localparam int DDR_DATA_W = 256;
  localparam int DDR_ADDR_W = 25;
  localparam int DDR_BE_W   = DDR_DATA_W / 8;
  localparam int DDR_BC_W   = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_BURST = 2'd2,
    ST_NEXT  = 2'd3
  } ddr_state_e;

  // Beats for the next burst: a full burst when enough words are buffered,
  // otherwise whatever is left (only used for flushes).
  function automatic logic [DDR_BC_W-1:0] burst_beats(input int unsigned avail,
                                                       input int unsigned burst_len);
    if (avail >= burst_len) begin
      burst_beats = DDR_BC_W'(burst_len);
    end else begin
      burst_beats = DDR_BC_W'(avail);
    end
  endfunction

endpackage

// File: rtl/ddr_wr_fifo.sv
// Synchronous first-word-fall-through FIFO buffering stream words ahead of DDR bursts.
module ddr_wr_fifo #(
  parameter int DATA_W = 256,
  parameter int DEPTH  = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     pop,
  output logic [DATA_W-1:0]        rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              wr_en_s, rd_en_s;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == {CNT_W{1'b0}});
  assign count = count_q;
  assign rdata = mem[rd_ptr_q];

  // Pointer and occupancy update; a push into a full FIFO is ignored, never bypassed.
  always_comb begin
    wr_en_s  = push & ~full;
    rd_en_s  = pop & ~empty;
    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_en_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    count_d = count_q + CNT_W'(wr_en_s) - CNT_W'(rd_en_s);
  end

  // Pointer/count registers; reset empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/ddr_stream_writer.sv
// Buffers a valid/ready word stream and writes it linearly into a DDR ring
// region as fixed-length Avalon-MM write bursts, with flush for residual words.
module ddr_stream_writer
  import ddr_pkg::*;
#(
  parameter int                DATA_W     = DDR_DATA_W,
  parameter int                ADDR_W     = DDR_ADDR_W,
  parameter int                BURST_LEN  = 16,
  parameter int                FIFO_DEPTH = 64,
  parameter logic [ADDR_W-1:0] ADDR_BASE  = ADDR_W'(25'h0000000),
  parameter logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(25'h1FFFFF0)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  setup_done,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_flush,
  output logic [ADDR_W-1:0]     amm_addr,
  output logic [DATA_W-1:0]     amm_writedata,
  output logic                  amm_write,
  output logic [DATA_W/8-1:0]   amm_byteenable,
  output logic [DDR_BC_W-1:0]   amm_burstcount,
  input  logic                  amm_ready,
  output logic                  busy,
  output logic                  wrap_pulse,
  output logic [31:0]           words_written
);

  localparam int               CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam int               BE_W      = DATA_W / 8;
  localparam logic [CNT_W-1:0] BURST_CNT = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  ddr_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                write_q, write_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [DDR_BC_W-1:0] bc_q, bc_d;
  logic [DDR_BC_W-1:0] beats_left_q, beats_left_d;
  logic                flush_pend_q, flush_pend_d;
  logic                in_ready_q, in_ready_d;
  logic                busy_q, busy_d;
  logic                wrap_q, wrap_d;
  logic [31:0]         words_written_q, words_written_d;

  logic                push_s, pop_s;
  logic [CNT_W-1:0]    fifo_count_s, count_next_s;
  logic                fifo_full_s, fifo_empty_s;
  logic [DATA_W-1:0]   fifo_rdata_s;
  logic [ADDR_W-1:0]   next_start_s;

  // in_ready is registered from next-cycle occupancy, so a push is only taken
  // when the FIFO was not full at the start of the cycle.
  assign push_s       = in_valid & in_ready_q & ~fifo_full_s;
  assign count_next_s = fifo_count_s + CNT_W'(push_s) - CNT_W'(pop_s);
  assign next_start_s = addr_q + ADDR_W'(bc_q);

  ddr_wr_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .wdata (in_data),
    .pop   (pop_s),
    .rdata (fifo_rdata_s),
    .count (fifo_count_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: a burst starts only when all its beats are already buffered.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (setup_done && (fifo_count_s >= BURST_CNT)) begin
          state_d = ST_LOAD;
        end else if (setup_done && flush_pend_q && !fifo_empty_s) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD:  state_d = ST_BURST;
      ST_BURST: begin
        if (amm_ready && (beats_left_q == DDR_BC_W'(1))) begin
          state_d = ST_NEXT;
        end else begin
          state_d = ST_BURST;
        end
      end
      ST_NEXT:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output/datapath next values: beat sequencing, address ring, flush, counters.
  always_comb begin
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    write_d      = write_q;
    be_d         = be_q;
    bc_d         = bc_q;
    beats_left_d = beats_left_q;
    wrap_d       = 1'b0;
    pop_s        = 1'b0;
    case (state_q)
      ST_LOAD: begin
        bc_d         = burst_beats(32'(fifo_count_s), BURST_LEN);
        beats_left_d = burst_beats(32'(fifo_count_s), BURST_LEN);
        wdata_d      = fifo_rdata_s;
        pop_s        = 1'b1;
        write_d      = 1'b1;
        be_d         = {BE_W{1'b1}};
      end
      ST_BURST: begin
        if (amm_ready) begin
          beats_left_d = beats_left_q - DDR_BC_W'(1);
          if (beats_left_q == DDR_BC_W'(1)) begin
            write_d = 1'b0;
            be_d    = {BE_W{1'b0}};
          end else begin
            wdata_d = fifo_rdata_s;
            pop_s   = 1'b1;
          end
        end else begin
          beats_left_d = beats_left_q;
        end
      end
      ST_NEXT: begin
        if (next_start_s > ADDR_LIMIT) begin
          addr_d = ADDR_BASE;
          wrap_d = 1'b1;
        end else begin
          addr_d = next_start_s;
          wrap_d = 1'b0;
        end
      end
      default: begin
        pop_s = 1'b0;
      end
    endcase

    if (in_flush && (!fifo_empty_s || push_s)) begin
      flush_pend_d = 1'b1;
    end else if ((state_q == ST_LOAD) && (fifo_count_s < BURST_CNT)) begin
      flush_pend_d = 1'b0;
    end else if (fifo_empty_s) begin
      flush_pend_d = 1'b0;
    end else begin
      flush_pend_d = flush_pend_q;
    end

    if (write_q && amm_ready && (words_written_q != 32'hFFFF_FFFF)) begin
      words_written_d = words_written_q + 32'd1;
    end else begin
      words_written_d = words_written_q;
    end

    busy_d     = (state_d != ST_IDLE) || (count_next_s != {CNT_W{1'b0}});
    in_ready_d = setup_done && (count_next_s < DEPTH_CNT);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q          <= ADDR_BASE;
      wdata_q         <= {DATA_W{1'b0}};
      write_q         <= 1'b0;
      be_q            <= {BE_W{1'b0}};
      bc_q            <= {DDR_BC_W{1'b0}};
      beats_left_q    <= {DDR_BC_W{1'b0}};
      flush_pend_q    <= 1'b0;
      in_ready_q      <= 1'b0;
      busy_q          <= 1'b0;
      wrap_q          <= 1'b0;
      words_written_q <= 32'd0;
    end else begin
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      write_q         <= write_d;
      be_q            <= be_d;
      bc_q            <= bc_d;
      beats_left_q    <= beats_left_d;
      flush_pend_q    <= flush_pend_d;
      in_ready_q      <= in_ready_d;
      busy_q          <= busy_d;
      wrap_q          <= wrap_d;
      words_written_q <= words_written_d;
    end
  end

  assign in_ready       = in_ready_q;
  assign amm_addr       = addr_q;
  assign amm_writedata  = wdata_q;
  assign amm_write      = write_q;
  assign amm_byteenable = be_q;
  assign amm_burstcount = bc_q;
  assign busy           = busy_q;
  assign wrap_pulse     = wrap_q;
  assign words_written  = words_written_q;

endmodule
